// File: rtl/cdma_spreader.sv
// cdma_spreader: buffers serial data bits and spreads each one over CODE_LEN
// chips of a Walsh code row, emitting contiguous symbols while bits are queued.
`default_nettype none

module cdma_spreader #(
  parameter int CODE_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic [CODE_W-1:0] code_sel,
  output logic              chip_out,
  output logic              chip_valid,
  output logic              sym_start,
  output logic              sym_last,
  output logic [CODE_W:0]   fifo_level
);

  localparam int                LVL_W   = CODE_W + 1;
  localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CODE_W-1:0] LAST    = {CODE_W{1'b1}};
  localparam logic [LVL_W-1:0]  FULL    = LVL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SPREAD} state_t;

  state_t            state, state_n;
  logic [CODE_W-1:0] chip_idx, chip_idx_n;
  logic [CODE_W-1:0] code_lat, code_lat_n;
  logic              data_bit, data_bit_n;
  logic              chip_n, valid_n, start_n, last_n;

  logic              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              push, pop;

  function automatic logic walsh(input logic [CODE_W-1:0] c, input logic [CODE_W-1:0] j);
    return ^(c & j);
  endfunction

  assign bit_ready = (fifo_level != FULL);
  assign push      = bit_valid && bit_ready;

  // Storage needs no reset: emptiness is defined entirely by fifo_level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bit_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      chip_idx   <= '0;
      code_lat   <= '0;
      data_bit   <= 1'b0;
      chip_out   <= 1'b0;
      chip_valid <= 1'b0;
      sym_start  <= 1'b0;
      sym_last   <= 1'b0;
    end else begin
      state      <= state_n;
      chip_idx   <= chip_idx_n;
      code_lat   <= code_lat_n;
      data_bit   <= data_bit_n;
      chip_out   <= chip_n;
      chip_valid <= valid_n;
      sym_start  <= start_n;
      sym_last   <= last_n;
    end
  end

  // Popping uses the level before this edge's push, so a bit never bypasses the buffer.
  always_comb begin
    pop        = 1'b0;
    state_n    = state;
    chip_idx_n = chip_idx;
    code_lat_n = code_lat;
    data_bit_n = data_bit;
    chip_n     = 1'b0;
    valid_n    = 1'b0;
    start_n    = 1'b0;
    last_n     = 1'b0;

    if ((state == IDLE || chip_idx == LAST) && fifo_level != '0) begin
      pop        = 1'b1;
      state_n    = SPREAD;
      chip_idx_n = '0;
      code_lat_n = code_sel;
      data_bit_n = mem[rd_ptr];
      chip_n     = mem[rd_ptr] ^ walsh(code_sel, '0);
      valid_n    = 1'b1;
      start_n    = 1'b1;
      last_n     = (LAST == '0);
    end else if (state == SPREAD && chip_idx != LAST) begin
      chip_idx_n = chip_idx + 1'b1;
      chip_n     = data_bit ^ walsh(code_lat, chip_idx_n);
      valid_n    = 1'b1;
      last_n     = (chip_idx_n == LAST);
    end else if (state == SPREAD) begin
      state_n    = IDLE;
      chip_idx_n = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdma_spreader.sv
// tb_cdma_spreader: directed stimulus with a chip scoreboard for cdma_spreader.
`default_nettype none

module tb_cdma_spreader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic [2:0] code_sel = 3'd0;
  logic       chip_out, chip_valid, sym_start, sym_last;
  logic [3:0] fifo_level;

  int tests = 0;
  int fails = 0;
  int nsym  = 0;
  int base;
  logic [2:0] sb [$];

  cdma_spreader #(.CODE_W(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .code_sel(code_sel), .chip_out(chip_out),
    .chip_valid(chip_valid), .sym_start(sym_start), .sym_last(sym_last),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic wal(input int c, input int j);
    return ($countones(c & j) % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each chip is {chip_out, sym_start, sym_last}.
  always @(negedge clk) begin
    if (chip_valid === 1'b1) begin
      if (sym_start) nsym++;
      if (sb.size() == 0) chk("unexpected_chip", 8'(chip_out), 8'hEE);
      else chk("chip", 8'({chip_out, sym_start, sym_last}), 8'(sb.pop_front()));
    end else begin
      chk("idle_outputs", 8'({chip_valid, chip_out, sym_start, sym_last}), 8'h0);
    end
  end

  task automatic push_bit(input logic b, input int code);
    logic acc;
    acc = 1'b0;
    bit_in    = b;
    bit_valid = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      acc = bit_ready;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    if (!acc) chk("push_timeout", 8'd0, 8'd1);
    for (int j = 0; j < 8; j++) sb.push_back({b ^ wal(code, j), j == 0, j == 7});
  endtask

  task automatic wait_start();
    int t;
    for (t = 0; t < 30 && !sym_start; t++) begin
      @(posedge clk); #1;
    end
    if (!sym_start) chk("start_timeout", 8'd0, 8'd1);
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 100 && (chip_valid || fifo_level != 0 || sb.size() != 0); t++) begin
      @(posedge clk); #1;
    end
    chk("drained_queue", 8'(sb.size()), 8'd0);
    chk("drained_valid", 8'(chip_valid), 8'd0);
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk("rst_outputs", 8'({chip_out, chip_valid, sym_start, sym_last}), 8'h0);
    chk("rst_level", 8'(fifo_level), 8'd0);
    chk("rst_ready", 8'(bit_ready), 8'd1);

    // Row 5, bit 0; push on first edge after release, chip 0 one edge later
    @(negedge clk); #1;
    rst = 1'b0;
    code_sel = 3'd5;
    push_bit(1'b0, 5);
    chk("lat_level", 8'(fifo_level), 8'd1);
    chk("lat_not_yet", 8'(chip_valid), 8'd0);
    @(posedge clk); #1;
    chk("lat_start", 8'({chip_valid, sym_start}), 8'b11);
    chk("lat_level_pop", 8'(fifo_level), 8'd0);
    wait_idle();

    // Row 5, bit 1
    push_bit(1'b1, 5);
    wait_idle();

    // Row 3, bits 1,0 back-to-back: 16 contiguous chips
    code_sel = 3'd3;
    push_bit(1'b1, 3);
    push_bit(1'b0, 3);
    wait_start();
    for (int i = 0; i < 16; i++) begin
      chk("contig_valid", 8'(chip_valid), 8'd1);
      @(posedge clk); #1;
    end
    wait_idle();

    // FIFO full while bit_valid held
    code_sel = 3'd5;
    base = nsym;
    for (int i = 0; i < 5; i++) push_bit(1'(i[0] ^ i[1]), 5);
    chk("full_ready", 8'(bit_ready), 8'd0);
    chk("full_level", 8'(fifo_level), 8'd4);
    for (int t = 0; t < 20 && !bit_ready; t++) begin
      @(posedge clk); #1;
    end
    chk("ready_after_pop", 8'({bit_ready, sym_start}), 8'b11);
    chk("level_after_pop", 8'(fifo_level), 8'd3);
    wait_idle();
    chk("symbols_eq_pushes", 8'(nsym - base), 8'd5);

    // code_sel change at chip 3 applies only to the next symbol
    code_sel = 3'd5;
    push_bit(1'b0, 5);
    push_bit(1'b1, 3);
    wait_start();
    repeat (3) begin
      @(posedge clk); #1;
    end
    code_sel = 3'd3;
    wait_idle();

    // Reset at chip 4 with 2 bits buffered
    code_sel = 3'd5;
    push_bit(1'b1, 5);
    wait_start();
    push_bit(1'b0, 5);
    push_bit(1'b1, 5);
    chk("pre_rst_level", 8'(fifo_level), 8'd2);
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst_mid_outputs", 8'({chip_out, chip_valid, sym_start, sym_last}), 8'h0);
    chk("rst_mid_level", 8'(fifo_level), 8'd0);
    chk("rst_mid_ready", 8'(bit_ready), 8'd1);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("post_rst_level", 8'(fifo_level), 8'd0);
    push_bit(1'b0, 5);
    chk("post_rst_push", 8'(fifo_level), 8'd1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
